// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU: round-robin grant,
// IDLE/EXEC/RESP sequencer, registered response tagged with the requester id.

module alu (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] sel,
    output logic [4:0] result,
    output logic       carry,
    output logic       zero,
    output logic       negative
);
    logic [5:0] diff;

    always_comb begin
        diff   = {2'b00, a} - {2'b00, b};
        result = 5'd0;
        carry  = 1'b0;
        case (sel)
            3'b000: result = {1'b0, a} + {1'b0, b};
            // Borrow lands in bit 5 of the 6-bit difference.
            3'b001: begin
                result = diff[4:0];
                carry  = diff[5];
            end
            3'b010: result = {1'b0, a & b};
            3'b011: result = {1'b0, a | b};
            3'b100: result = {1'b0, a ^ b};
            3'b101: result = {a, 1'b0};
            3'b110: result = {2'b00, a[3:1]};
            3'b111: result = {4'b0000, a == b};
            default: result = 5'd0;
        endcase
        zero     = (result == 5'd0);
        negative = result[4];
    end
endmodule

module alu_arbiter_port (
    input  logic valid,
    input  logic grant,
    input  logic idle,
    input  logic rst,
    output logic ready,
    output logic fire
);
    assign ready = idle & grant & ~rst;
    assign fire  = valid & ready;
endmodule

module alu_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [2:0] req0_sel,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [2:0] req1_sel,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [4:0] rsp_result,
    output logic       rsp_carry,
    output logic       rsp_zero,
    output logic       rsp_negative,
    output logic [7:0] ops_done
);
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] sel;
        logic       id;
    } op_t;

    state_t state;
    logic   last;
    op_t    op;

    logic [NUM_REQ-1:0]      valid_vec, grant, ready_vec, fire;
    logic [NUM_REQ-1:0][3:0] a_vec, b_vec;
    logic [NUM_REQ-1:0][2:0] sel_vec;

    logic [4:0] alu_result;
    logic       alu_carry, alu_zero, alu_negative;

    assign valid_vec = {req1_valid, req0_valid};
    assign a_vec     = {req1_a, req0_a};
    assign b_vec     = {req1_b, req0_b};
    assign sel_vec   = {req1_sel, req0_sel};

    // On contention the requester that was not served last wins.
    always_comb begin
        grant = valid_vec;
        if (valid_vec == 2'b11)
            grant = last ? 2'b01 : 2'b10;
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
        alu_arbiter_port u_port (
            .valid (valid_vec[i]),
            .grant (grant[i]),
            .idle  (state == IDLE),
            .rst   (rst),
            .ready (ready_vec[i]),
            .fire  (fire[i])
        );
    end

    assign req0_ready = ready_vec[0];
    assign req1_ready = ready_vec[1];

    alu u_alu (
        .a        (op.a),
        .b        (op.b),
        .sel      (op.sel),
        .result   (alu_result),
        .carry    (alu_carry),
        .zero     (alu_zero),
        .negative (alu_negative)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last         <= 1'b1;
            op           <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= 5'd0;
            rsp_carry    <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_negative <= 1'b0;
            ops_done     <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (|fire) begin
                        op.a   <= a_vec[fire[1]];
                        op.b   <= b_vec[fire[1]];
                        op.sel <= sel_vec[fire[1]];
                        op.id  <= fire[1];
                        last   <= fire[1];
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_id       <= op.id;
                    rsp_result   <= alu_result;
                    rsp_carry    <= alu_carry;
                    rsp_zero     <= alu_zero;
                    rsp_negative <= alu_negative;
                    rsp_valid    <= 1'b1;
                    state        <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ops_done  <= ops_done + 8'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter against an arithmetic model
// of the ALU, a round-robin "last served" tracker and a handshake counter.

module tb_alu_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0] req0_sel = '0, req1_sel = '0;
    logic       rsp_valid, rsp_ready = 1'b1, rsp_id;
    logic [4:0] rsp_result;
    logic       rsp_carry, rsp_zero, rsp_negative;
    logic [7:0] ops_done;

    int   checks = 0;
    int   errors = 0;
    int   exp_ops = 0;
    logic last_m = 1'b1;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry),
        .rsp_zero(rsp_zero), .rsp_negative(rsp_negative),
        .ops_done(ops_done)
    );

    // {result[4:0], carry, zero, negative}
    function automatic logic [7:0] ref_alu(input int a, input int b, input int sel);
        int r;
        int c;
        r = 0;
        c = 0;
        case (sel)
            0: r = a + b;
            1: begin r = (a - b) & 31; c = (a < b) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (a * 2) % 32;
            6: r = a / 2;
            7: r = (a == b) ? 1 : 0;
            default: r = 0;
        endcase
        return {r[4:0], c[0], r == 0, r >= 16};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_ops = 0;
        last_m = 1'b1;
    endtask

    // Single-requester operation with rsp_ready high: accept, EXEC, RESP, handshake.
    task automatic transact(input logic id, input logic [3:0] a, input logic [3:0] b,
                            input logic [2:0] sel, input string tag);
        logic [7:0] exp;
        exp = ref_alu(a, b, sel);
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel;
        end
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== (id ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL %s ready: got %b expected %b", tag, {req1_ready, req0_ready}, id ? 2'b10 : 2'b01);
        end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        last_m = id;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s exec_valid: got %b expected 0", tag, rsp_valid);
        end
        step();
        checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_negative} !== {1'b1, id, exp}) begin
            errors++;
            $display("FAIL %s rsp: got v=%b id=%b res=%0d c=%b z=%b n=%b expected v=1 id=%b res=%0d c=%b z=%b n=%b",
                     tag, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_negative,
                     id, exp[7:3], exp[2], exp[1], exp[0]);
        end
        step();
        exp_ops = (exp_ops + 1) % 256;
        checks++;
        if (ops_done !== exp_ops[7:0] || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s done: got ops=%0d v=%b expected ops=%0d v=0", tag, ops_done, rsp_valid, exp_ops);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        step();
        step();
        checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_negative, ops_done} !== 18'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%b id=%b res=%0d c=%b z=%b n=%b ops=%0d expected all 0",
                     rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_negative, ops_done);
        end
        checks++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 00", {req1_ready, req0_ready});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        exp_ops = 0;
        last_m = 1'b1;
        step();
        transact(1'b0, 4'd9, 4'd7, 3'b000, "add_9_7");
    endtask

    task automatic test_sub_borrow();
        transact(1'b1, 4'd2, 4'd3, 3'b001, "sub_borrow");
    endtask

    task automatic test_contention();
        logic       win;
        logic [7:0] exp0, exp1;
        do_reset();
        rsp_ready = 1'b1;
        req0_a = 4'($urandom); req0_b = 4'($urandom); req0_sel = 3'($urandom);
        req1_a = 4'($urandom); req1_b = 4'($urandom); req1_sel = 3'($urandom);
        exp0 = ref_alu(req0_a, req0_b, req0_sel);
        exp1 = ref_alu(req1_a, req1_b, req1_sel);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            win = ~last_m;
            checks++;
            if ({req1_ready, req0_ready} !== (win ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL contention_grant%0d: got %b expected %b", k, {req1_ready, req0_ready}, win ? 2'b10 : 2'b01);
            end
            step();
            last_m = win;
            checks++;
            if ({req1_ready, req0_ready, rsp_valid} !== 3'b000) begin
                errors++;
                $display("FAIL contention_exec%0d: got rdy=%b v=%b expected 00 0", k, {req1_ready, req0_ready}, rsp_valid);
            end
            step();
            checks++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_negative} !== {1'b1, win, win ? exp1 : exp0}) begin
                errors++;
                $display("FAIL contention_rsp%0d: got v=%b id=%b res=%0d expected id=%b res=%0d",
                         k, rsp_valid, rsp_id, rsp_result, win, win ? exp1[7:3] : exp0[7:3]);
            end
            step();
            exp_ops++;
        end
        checks++;
        if (ops_done !== 8'd4) begin
            errors++;
            $display("FAIL contention_ops: got %0d expected 4", ops_done);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd5; req0_sel = 3'b111;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_accept: got %b expected 01", {req1_ready, req0_ready});
        end
        step();
        req0_valid = 1'b0;
        last_m = 1'b0;
        req1_valid = 1'b1; req1_a = 4'($urandom); req1_b = 4'($urandom); req1_sel = 3'($urandom);
        step();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({rsp_valid, rsp_id, rsp_result, req1_ready, req0_ready} !== {1'b1, 1'b0, 5'd1, 2'b00}) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b id=%b res=%0d rdy=%b expected v=1 id=0 res=1 rdy=00",
                         k, rsp_valid, rsp_id, rsp_result, {req1_ready, req0_ready});
            end
            step();
        end
        rsp_ready = 1'b1;
        step();
        exp_ops++;
        checks++;
        if (ops_done !== exp_ops[7:0] || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got ops=%0d v=%b expected ops=%0d v=0", ops_done, rsp_valid, exp_ops);
        end
        // The request that waited through the handshake is offered only now, in IDLE.
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            errors++;
            $display("FAIL bp_late_req: got %b expected 10", {req1_ready, req0_ready});
        end
        req1_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset_in_resp();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 4'($urandom); req0_b = 4'($urandom); req0_sel = 3'($urandom);
        #1;
        step();
        req0_valid = 1'b0;
        step();
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rr_in_resp: got v=%b expected 1", rsp_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_ops = 0;
        last_m = 1'b1;
        checks++;
        if ({rsp_valid, rsp_result, ops_done} !== 14'd0) begin
            errors++;
            $display("FAIL rr_cleared: got v=%b res=%0d ops=%0d expected 0 0 0", rsp_valid, rsp_result, ops_done);
        end
        rsp_ready = 1'b1;
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_no_rsp: got v=%b expected 0", rsp_valid);
        end
        transact(1'b1, 4'd15, 4'd1, 3'b000, "rr_next");
    endtask

    task automatic test_random();
        int         v, waits;
        logic       win;
        logic [7:0] exp;
        for (int k = 0; k < 40; k++) begin
            v = $urandom_range(1, 3);
            req0_a = 4'($urandom); req0_b = 4'($urandom); req0_sel = 3'($urandom);
            req1_a = 4'($urandom); req1_b = 4'($urandom); req1_sel = 3'($urandom);
            req0_valid = v[0];
            req1_valid = v[1];
            win = (v == 3) ? ~last_m : (v == 2);
            exp = win ? ref_alu(req1_a, req1_b, req1_sel) : ref_alu(req0_a, req0_b, req0_sel);
            #1;
            checks++;
            if ({req1_ready, req0_ready} !== (win ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL rand_grant%0d: got %b expected %b", k, {req1_ready, req0_ready}, win ? 2'b10 : 2'b01);
            end
            step();
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            last_m = win;
            rsp_ready = 1'b0;
            step();
            waits = $urandom_range(0, 3);
            for (int w = 0; w <= waits; w++) begin
                checks++;
                if ({rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_negative} !== {1'b1, win, exp}) begin
                    errors++;
                    $display("FAIL rand_rsp%0d: got v=%b id=%b res=%0d c=%b z=%b n=%b expected id=%b res=%0d c=%b z=%b n=%b",
                             k, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_negative,
                             win, exp[7:3], exp[2], exp[1], exp[0]);
                end
                if (w < waits) step();
            end
            rsp_ready = 1'b1;
            step();
            exp_ops = (exp_ops + 1) % 256;
            checks++;
            if (ops_done !== exp_ops[7:0]) begin
                errors++;
                $display("FAIL rand_ops%0d: got %0d expected %0d", k, ops_done, exp_ops);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        rsp_ready = 1'b1;
        for (int k = 0; k < 256; k++)
            transact(1'(k), 4'($urandom), 4'($urandom), 3'($urandom), "wrap_op");
        checks++;
        if (ops_done !== 8'd0) begin
            errors++;
            $display("FAIL wrap_zero: got %0d expected 0", ops_done);
        end
    endtask

    initial begin
        test_reset();
        test_sub_borrow();
        test_contention();
        test_backpressure();
        test_reset_in_resp();
        test_random();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
